// File: rtl/npc_pkg.sv
// Shared types and constants for the next-PC / branch prediction unit.
package npc_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    localparam logic [1:0] SNT = 2'd0;
    localparam logic [1:0] WNT = 2'd1;
    localparam logic [1:0] WT  = 2'd2;
    localparam logic [1:0] ST  = 2'd3;

    typedef enum logic [1:0] {
        SEL_SEQ,
        SEL_PEND,
        SEL_HOLD,
        SEL_REDIR
    } npc_sel_e;

    // Two-bit saturating step towards the observed direction.
    function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken) begin
            if (ctr != ST) res = ctr + 2'd1;
        end else begin
            if (ctr != SNT) res = ctr - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/npc_btb.sv
// Direct-mapped branch target buffer: combinational lookup port plus a
// single update/allocate port driven by the ID-stage resolver.
module npc_btb
    import npc_pkg::*;
#(
    parameter int BTB_ENTRIES = 16,
    parameter int IDX_W       = $clog2(BTB_ENTRIES)
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] lookup_pc,
    output logic        lookup_taken,
    output logic [31:0] lookup_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_is_cond,
    input  logic        upd_taken,
    input  logic [31:0] upd_target
);

    localparam int TAG_W = 32 - IDX_W - 2;

    logic [BTB_ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
    logic [31:0]            target_q [BTB_ENTRIES];
    logic [1:0]             ctr_q    [BTB_ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic             unused_bits;

    assign lk_idx = lookup_pc[IDX_W+1:2];
    assign lk_tag = lookup_pc[31:IDX_W+2];
    assign up_idx = upd_pc[IDX_W+1:2];
    assign up_tag = upd_pc[31:IDX_W+2];

    // Instructions are word aligned, so the byte offset never matters.
    assign unused_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

    always_comb begin
        lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        lookup_taken  = lk_hit && ctr_q[lk_idx][1];
        lookup_target = lk_hit ? target_q[lk_idx] : 32'd0;
        up_hit        = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    end

    // A resolved not-taken branch that misses leaves the table untouched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= SNT;
            end
        end else if (upd_valid) begin
            if (up_hit) begin
                if (upd_is_cond) begin
                    ctr_q[up_idx] <= ctr_update(ctr_q[up_idx], upd_taken);
                    if (upd_taken) target_q[up_idx] <= upd_target;
                end else begin
                    ctr_q[up_idx]    <= ST;
                    target_q[up_idx] <= upd_target;
                end
            end else if (upd_taken) begin
                valid_q[up_idx]  <= 1'b1;
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= upd_target;
                ctr_q[up_idx]    <= upd_is_cond ? WT : ST;
            end
        end
    end

endmodule

// File: rtl/npc_bpu.sv
// Fetch PC register with BTB-driven prediction, delay-slot pending target
// and misprediction redirect from the ID-stage resolver.
module npc_bpu
    import npc_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int          BTB_ENTRIES = 16,
    parameter int          IDX_W       = $clog2(BTB_ENTRIES)
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_add8_o,
    output logic        pred_taken_o,
    output logic [31:0] pred_target_o,
    input  logic        upd_valid_i,
    input  logic [31:0] upd_pc_i,
    input  logic        upd_is_cond_i,
    input  logic        upd_taken_i,
    input  logic [31:0] upd_target_i,
    input  logic        upd_mispredict_i,
    input  logic [31:0] redir_pc_i
);

    logic        pend_valid;
    logic [31:0] pend_target;
    npc_sel_e    sel;

    npc_btb #(
        .BTB_ENTRIES(BTB_ENTRIES),
        .IDX_W      (IDX_W)
    ) u_btb (
        .clk          (clk),
        .reset_n      (reset_n),
        .lookup_pc    (pc_o),
        .lookup_taken (pred_taken_o),
        .lookup_target(pred_target_o),
        .upd_valid    (upd_valid_i),
        .upd_pc       (upd_pc_i),
        .upd_is_cond  (upd_is_cond_i),
        .upd_taken    (upd_taken_i),
        .upd_target   (upd_target_i)
    );

    assign pc_add8_o = pc_o + 32'd8;

    // A redirect beats a stall: the resolver's correction must never be lost.
    always_comb begin
        sel = SEL_SEQ;
        if (upd_valid_i && upd_mispredict_i) sel = SEL_REDIR;
        else if (stall_i)                    sel = SEL_HOLD;
        else if (pend_valid)                 sel = SEL_PEND;
    end

    // Leaving the delay slot always drops pend, so a predicted-taken
    // delay-slot instruction cannot arm a second pending target.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_o        <= RESET_PC;
            pend_valid  <= 1'b0;
            pend_target <= '0;
        end else begin
            unique case (sel)
                SEL_REDIR: begin
                    pc_o       <= redir_pc_i;
                    pend_valid <= 1'b0;
                end
                SEL_HOLD: begin
                    pc_o       <= pc_o;
                    pend_valid <= pend_valid;
                end
                SEL_PEND: begin
                    pc_o       <= pend_target;
                    pend_valid <= 1'b0;
                end
                SEL_SEQ: begin
                    pc_o       <= pc_o + 32'd4;
                    pend_valid <= pred_taken_o;
                    if (pred_taken_o) pend_target <= pred_target_o;
                end
            endcase
        end
    end

endmodule

// File: doc/npc_bpu.md
# npc_bpu

Parametrised next-PC unit with dynamic branch prediction for the pipelined MIPS core. Owns the fetch PC register and predicts control-flow targets from a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. It honours the architectural branch delay slot, and redirects the fetch stream when the ID-stage resolver reports a misprediction. It sits between the IF stage and the ID-stage branch comparator, and replaces the combinational next-PC selector.

## Interface
- RESET_PC, 32'h0000_3000, fetch PC after reset
- BTB_ENTRIES, 16, BTB depth; power of two, 2..256
- IDX_W, $clog2(BTB_ENTRIES), index width (derived)
- clk  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- stall_i  in  1  IF/ID hold request
- pc_o  out  32  current fetch PC (registered)
- pc_add8_o  out  32  pc_o + 8, link value
- pred_taken_o  out  1  pc_o is predicted taken; travels down the pipe with the instruction
- pred_target_o  out  32  predicted target for pc_o; valid when pred_taken_o=1
- upd_valid_i  in  1  ID has resolved a control-flow instruction this cycle
- upd_pc_i  in  32  PC of the resolved instruction
- upd_is_cond_i  in  1  1 = conditional branch; 0 = j/jal/jr/jalr
- upd_taken_i  in  1  actual direction
- upd_target_i  in  32  actual target
- upd_mispredict_i  in  1  carried prediction differs from outcome (direction or target); qualified by upd_valid_i
- redir_pc_i  in  32  correct PC after the delay slot: target if taken, upd_pc_i+8 otherwise

## Operation
- BTB entry: valid, tag = pc[31:IDX_W+2], index = pc[IDX_W+1:2], target[31:0], ctr[1:0].
- Lookup on pc_o is combinational. hit = valid & tag match. pred_taken_o = hit & ctr[1]. pred_target_o = stored target, or 0 on miss.
- Delay slot handling:
  - A predicted-taken fetch does not change the following fetch; pc_o+4 (the delay slot) is fetched next.
  - On that fetch, register pend_valid=1 and pend_target=pred_target_o.
  - When the delay slot advances, next PC = pend_target and pend_valid clears.
- Next-PC priority, highest first:
  - redirect (upd_valid_i & upd_mispredict_i) → redir_pc_i, clear pend_valid; this overrides stall_i.
  - stall_i → hold pc_o and the pend state.
  - pend_valid → pend_target.
  - otherwise → pc_o+4.
- pend_valid is set only by a non-stalled, non-redirected fetch with pred_taken_o=1. A predicted-taken delay-slot instruction never re-arms pend.
- BTB update on upd_valid_i (regardless of mispredict):
  - Hit, conditional: ctr saturating +1 if taken, −1 if not taken. Target is rewritten when taken.
  - Hit, unconditional: ctr=3, target rewritten.
  - Miss and taken: allocate (overwrite the indexed entry). ctr=2 if conditional, 3 if unconditional.
  - Miss and not taken: no change.
- Counter arithmetic is 2-bit saturating: 3+1=3, 0−1=0. PC arithmetic is 32-bit modulo (wraps at 2^32).

## Timing
- Reset (asynchronous assert; release takes effect at the next rising edge):
  - pc_o=RESET_PC, pc_add8_o=RESET_PC+8.
  - All BTB valid=0, so pred_taken_o=0 and pred_target_o=0.
  - pend_valid=0.
- pc_o updates on the rising edge following the selection. A redirect presented in cycle N makes pc_o=redir_pc_i in cycle N+1.
- A BTB update written at edge N is visible to lookups from cycle N+1. A same-cycle lookup and update to the same index read the old contents.
- Prediction latency: a branch at address A fetched in cycle N gives pc_o=A+4 in N+1 and pc_o=target in N+2 (no stall).
- Stall during pend: pend is held, and the target is issued on the first non-stalled edge after the delay slot.
- Reset mid-operation discards pend and the whole BTB. No update is accepted while reset_n=0.

## Structure
- Package npc_pkg:
  - RESET_PC default.
  - Counter encodings SNT=2'd0, WNT=2'd1, WT=2'd2, ST=2'd3.
  - Next-PC select enum: SEL_SEQ, SEL_PEND, SEL_HOLD, SEL_REDIR.
- Sub-module npc_btb holds the flop-based entry array, read port, and update/allocate logic, parametrised by BTB_ENTRIES.
- npc_bpu holds the PC register, pend register, and priority mux.

## Test plan
- Reset release with no updates → pc_o sequence 0x3000, 0x3004, 0x3008; pred_taken_o=0 throughout.
- Update for beq at 0x3010 (conditional, taken, target 0x3100), then refetch 0x3010 → pred_taken_o=1 with target 0x3100. Next cycles give pc_o=0x3014, then 0x3100.
- Same branch resolved not-taken twice → ctr goes 2→1→0. The next fetch of 0x3010 gives pred_taken_o=0 and pc_o=0x3014, 0x3018.
- Mispredict with redir_pc_i=0x3018 asserted while stall_i=1 and pend_valid=1 → pc_o=0x3018 next cycle and pend cleared.
- Alias check: with BTB_ENTRIES=16, an entry at 0x3010 followed by a taken update from 0x3050 (same index, different tag). A fetch of 0x3010 then misses, and 0x3050 hits with ctr=2.
- jr at 0x3020 updated twice, targets 0x3400 then 0x3500 → the lookup returns 0x3500 with ctr=3. An asynchronous reset asserted mid-pend → pc_o=0x3000 immediately and pred_taken_o=0.
